mem_stage_ctrl: RTL and testbench
=================================

// Module: mem_stage_ctrl
// PURPOSE
//  Consumer of the EX/MEM pipeline register. Turns the latched ALU result, store data and
//  memory enables into a request to a multi-cycle data memory and stalls the front of the pipe
//  until the access completes. Delivers a one-cycle-valid result (load data or ALU result) to
//  the MEM/WB stage, and owns halt capture and memory-timeout detection.
// PARAMETERS
//  DATA_W       16  width of data, address and result buses
//  TIMEOUT_CYC  15  BUSY cycles without mem_done before abort (1..255)
// PORTS
//  clk          in   1       clock, rising edge
//  rst          in   1       asynchronous reset, active-low (0 = reset)
//  ex_valid     in   1       EX/MEM register holds a live instruction
//  ex_addr      in   DATA_W  ALU result: memory address, or passthrough result
//  ex_wdata     in   DATA_W  store data (read2OutData)
//  ex_rd_en     in   1       load
//  ex_wr_en     in   1       store (mem_writeEn)
//  ex_halt      in   1       HALT instruction
//  stall        out  1       upstream must hold EX/MEM contents (combinational)
//  mem_req      out  1       one-cycle request pulse to data memory
//  mem_wr       out  1       request is a write
//  mem_addr     out  DATA_W  request address (registered, stable while BUSY)
//  mem_wdata    out  DATA_W  request write data (registered)
//  mem_rdata    in   DATA_W  read data, valid with mem_done
//  mem_done     in   1       access complete
//  wb_valid     out  1       result valid to MEM/WB, one cycle
//  wb_data      out  DATA_W  load data, or ex_addr for stores/non-memory ops
//  wb_err       out  1       qualifies wb_valid: access aborted (timeout/misaligned)
//  halt_q       out  1       sticky: HALT retired
// BEHAVIOUR
//  Reset: state=IDLE, cnt=0; mem_req, mem_wr, mem_addr, mem_wdata, wb_valid, wb_data, wb_err,
//   halt_q all 0. Reset mid-access abandons it; any later mem_done in IDLE is ignored.
//  States: IDLE, BUSY.
//  is_mem = ex_rd_en | ex_wr_en; both set -> write (read ignored).
//  IDLE, ex_valid & halt_q==0:
//   - ex_halt: halt_q<=1 at edge, wb_valid<=1, wb_data<=ex_addr; no memory op.
//   - !is_mem: wb_valid<=1, wb_data<=ex_addr (latency 1), stall=0.
//   - is_mem: stall=1; at edge -> BUSY, mem_req<=1, mem_wr<=ex_wr_en,
//     mem_addr<=ex_addr, mem_wdata<=ex_wdata, cnt<=0.
//  IDLE, halt_q==1: all ex_valid ignored, stall=0, no wb_valid, no mem_req.
//  BUSY: mem_req high only in first BUSY cycle; cnt increments every BUSY cycle; stall=1
//   except in the terminating cycle.
//   - mem_done (incl. first BUSY cycle): stall=0; at edge -> IDLE, wb_valid<=1, wb_err<=0,
//     wb_data<=mem_rdata (read) or mem_addr (write).
//   - cnt==TIMEOUT_CYC-1 without done: stall=0; at edge -> IDLE, wb_valid<=1, wb_err<=1,
//     wb_data<=mem_addr. done and timeout in same cycle: done wins.
//  wb_valid/wb_err deassert the cycle after they assert unless a new completion occurs.
//  Memory-op latency: ex_valid -> wb_valid = 2 + (cycles from mem_req to mem_done).
//  Upstream must hold ex_* stable while stall=1; block samples them only in IDLE.
// CONFIGURATION
//  ALIGN_CHECK_EN defined: in IDLE an is_mem op with ex_addr[0]==1 issues no mem_req;
//   at edge wb_valid<=1, wb_err<=1, wb_data<=ex_addr, stays IDLE, stall=0.
//  Undefined: no alignment check; odd addresses go to memory unchanged, wb_err only on timeout.
// TESTING
//  ALU op ex_addr=16'h1234, no enables -> next cycle wb_valid=1, wb_data=16'h1234, stall=0.
//  Load addr 16'h0040, mem_done 3 cycles after mem_req, mem_rdata=16'hBEEF -> stall high
//   4 cycles, wb_data=16'hBEEF, wb_err=0.
//  Store addr 16'h0010 wdata 16'hA5A5, done in first BUSY cycle -> mem_wr=1, mem_wdata=16'hA5A5,
//   wb_data=16'h0010.
//  TIMEOUT_CYC=4, mem_done never -> wb_valid=1, wb_err=1 after 4 BUSY cycles; state IDLE.
//  HALT then load -> halt_q=1 stays set, no mem_req for the load; reset (rst=0) mid-BUSY ->
//   all outputs 0 immediately, late mem_done ignored.
//  ALIGN_CHECK_EN: load addr 16'h0041 -> no mem_req, wb_err=1 next cycle.

Source files
------------

// File: rtl/mem_stage_ctrl_if.sv
// EX/MEM -> data memory -> MEM/WB signal bundle for mem_stage_ctrl.
// master = the memory stage controller, slave = the pipe/memory around it.
interface mem_stage_ctrl_if #(parameter int DATA_W = 16);
  logic              ex_valid;
  logic [DATA_W-1:0] ex_addr;
  logic [DATA_W-1:0] ex_wdata;
  logic              ex_rd_en;
  logic              ex_wr_en;
  logic              ex_halt;
  logic              stall;
  logic              mem_req;
  logic              mem_wr;
  logic [DATA_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_done;
  logic              wb_valid;
  logic [DATA_W-1:0] wb_data;
  logic              wb_err;
  logic              halt_q;

  modport master (
    input  ex_valid, ex_addr, ex_wdata, ex_rd_en, ex_wr_en, ex_halt, mem_rdata, mem_done,
    output stall, mem_req, mem_wr, mem_addr, mem_wdata, wb_valid, wb_data, wb_err, halt_q
  );

  modport slave (
    output ex_valid, ex_addr, ex_wdata, ex_rd_en, ex_wr_en, ex_halt, mem_rdata, mem_done,
    input  stall, mem_req, mem_wr, mem_addr, mem_wdata, wb_valid, wb_data, wb_err, halt_q
  );
endinterface

// File: rtl/mem_stage_ctrl.sv
// MEM stage controller: issues multi-cycle data-memory requests, stalls the front of the pipe,
// hands results to MEM/WB, captures HALT and aborts on timeout. Option macro: ALIGN_CHECK_EN.
module mem_stage_ctrl #(
  parameter int DATA_W      = 16,
  parameter int TIMEOUT_CYC = 15
) (
  input  logic              clk,
  input  logic              rst,
  mem_stage_ctrl_if.master  bus
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYC - 1);

  logic [0:0] state;
  logic [7:0] cnt;
  logic       is_mem, take, misalign, done_hit, tmo_hit;

  assign is_mem = bus.ex_rd_en | bus.ex_wr_en;
  assign take   = (state == IDLE) & bus.ex_valid & ~bus.halt_q;

`ifdef ALIGN_CHECK_EN
  assign misalign = bus.ex_addr[0];
`else
  assign misalign = 1'b0;
`endif

  assign done_hit = (state == BUSY) & bus.mem_done;
  assign tmo_hit  = (state == BUSY) & ~bus.mem_done & (cnt == CNT_LAST);

  // Gated by reset so every output reads 0 while reset is held.
  assign bus.stall = rst & ((take & ~bus.ex_halt & is_mem & ~misalign) |
                            ((state == BUSY) & ~done_hit & ~tmo_hit));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      cnt           <= '0;
      bus.mem_req   <= 1'b0;
      bus.mem_wr    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.wb_valid  <= 1'b0;
      bus.wb_data   <= '0;
      bus.wb_err    <= 1'b0;
      bus.halt_q    <= 1'b0;
    end else begin
      bus.mem_req  <= 1'b0;
      bus.wb_valid <= 1'b0;
      bus.wb_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (take) begin
            if (bus.ex_halt) begin
              bus.halt_q   <= 1'b1;
              bus.wb_valid <= 1'b1;
              bus.wb_data  <= bus.ex_addr;
            end else if (!is_mem) begin
              bus.wb_valid <= 1'b1;
              bus.wb_data  <= bus.ex_addr;
            end else if (misalign) begin
              bus.wb_valid <= 1'b1;
              bus.wb_err   <= 1'b1;
              bus.wb_data  <= bus.ex_addr;
            end else begin
              // Write wins when both enables are set.
              state         <= BUSY;
              cnt           <= '0;
              bus.mem_req   <= 1'b1;
              bus.mem_wr    <= bus.ex_wr_en;
              bus.mem_addr  <= bus.ex_addr;
              bus.mem_wdata <= bus.ex_wdata;
            end
          end
        end
        BUSY: begin
          cnt <= cnt + 8'd1;
          if (done_hit) begin
            state        <= IDLE;
            bus.wb_valid <= 1'b1;
            bus.wb_data  <= bus.mem_wr ? bus.mem_addr : bus.mem_rdata;
          end else if (tmo_hit) begin
            state        <= IDLE;
            bus.wb_valid <= 1'b1;
            bus.wb_err   <= 1'b1;
            bus.wb_data  <= bus.mem_addr;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl (built with TIMEOUT_CYC=4); follows ALIGN_CHECK_EN.
module tb_mem_stage_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  mem_stage_ctrl_if #(.DATA_W(16)) bus ();

  mem_stage_ctrl #(.DATA_W(16), .TIMEOUT_CYC(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    bus.ex_valid = 1'b0; bus.ex_addr = '0; bus.ex_wdata = '0;
    bus.ex_rd_en = 1'b0; bus.ex_wr_en = 1'b0; bus.ex_halt = 1'b0;
    bus.mem_done = 1'b0; bus.mem_rdata = '0;
  endtask

  initial begin
    idle_in();
    tick();
    chk("rst_wb_valid", 32'(bus.wb_valid), 0);
    chk("rst_halt_q",   32'(bus.halt_q),   0);
    chk("rst_mem_req",  32'(bus.mem_req),  0);
    chk("rst_stall",    32'(bus.stall),    0);
    chk("rst_wb_data",  32'(bus.wb_data),  0);
    rst = 1'b1;
    tick();

    // ALU passthrough
    bus.ex_valid = 1'b1; bus.ex_addr = 16'h1234;
    #1 chk("alu_stall", 32'(bus.stall), 0);
    tick(); bus.ex_valid = 1'b0;
    chk("alu_wb_valid", 32'(bus.wb_valid), 1);
    chk("alu_wb_data",  32'(bus.wb_data),  32'h1234);
    chk("alu_wb_err",   32'(bus.wb_err),   0);
    tick();
    chk("alu_wb_drop",  32'(bus.wb_valid), 0);

    // Load, mem_done 3 cycles after mem_req
    bus.ex_valid = 1'b1; bus.ex_rd_en = 1'b1; bus.ex_addr = 16'h0040;
    #1 chk("ld_stall_c0", 32'(bus.stall), 1);
    tick();
    chk("ld_req",       32'(bus.mem_req),  1);
    chk("ld_wr",        32'(bus.mem_wr),   0);
    chk("ld_addr",      32'(bus.mem_addr), 32'h0040);
    chk("ld_stall_c1",  32'(bus.stall),    1);
    tick();
    chk("ld_req_drop",  32'(bus.mem_req),  0);
    chk("ld_stall_c2",  32'(bus.stall),    1);
    tick();
    chk("ld_stall_c3",  32'(bus.stall),    1);
    tick();
    bus.mem_done = 1'b1; bus.mem_rdata = 16'hBEEF;
    #1 chk("ld_stall_c4", 32'(bus.stall),  0);
    tick(); idle_in();
    chk("ld_wb_valid",  32'(bus.wb_valid), 1);
    chk("ld_wb_data",   32'(bus.wb_data),  32'hBEEF);
    chk("ld_wb_err",    32'(bus.wb_err),   0);

    // Store with both enables set, done in first BUSY cycle
    bus.ex_valid = 1'b1; bus.ex_wr_en = 1'b1; bus.ex_rd_en = 1'b1;
    bus.ex_addr = 16'h0010; bus.ex_wdata = 16'hA5A5;
    tick();
    chk("st_req",       32'(bus.mem_req),   1);
    chk("st_wr",        32'(bus.mem_wr),    1);
    chk("st_wdata",     32'(bus.mem_wdata), 32'hA5A5);
    bus.mem_done = 1'b1; bus.mem_rdata = 16'hFFFF;
    #1 chk("st_stall",  32'(bus.stall),     0);
    tick(); idle_in();
    chk("st_wb_valid",  32'(bus.wb_valid),  1);
    chk("st_wb_data",   32'(bus.wb_data),   32'h0010);
    chk("st_wb_err",    32'(bus.wb_err),    0);

    // Timeout after 4 BUSY cycles
    bus.ex_valid = 1'b1; bus.ex_rd_en = 1'b1; bus.ex_addr = 16'h0022;
    tick(); tick(); tick();
    chk("to_stall_b3",  32'(bus.stall),    1);
    tick();
    chk("to_stall_b4",  32'(bus.stall),    0);
    chk("to_early",     32'(bus.wb_valid), 0);
    tick(); idle_in();
    chk("to_wb_valid",  32'(bus.wb_valid), 1);
    chk("to_wb_err",    32'(bus.wb_err),   1);
    chk("to_wb_data",   32'(bus.wb_data),  32'h0022);
    tick();
    chk("to_err_drop",  32'(bus.wb_err),   0);
    chk("to_idle_req",  32'(bus.mem_req),  0);

    // Odd address
    bus.ex_valid = 1'b1; bus.ex_rd_en = 1'b1; bus.ex_addr = 16'h0041;
`ifdef ALIGN_CHECK_EN
    #1 chk("odd_stall", 32'(bus.stall),    0);
    tick(); idle_in();
    chk("odd_req",      32'(bus.mem_req),  0);
    chk("odd_wb_valid", 32'(bus.wb_valid), 1);
    chk("odd_wb_err",   32'(bus.wb_err),   1);
    chk("odd_wb_data",  32'(bus.wb_data),  32'h0041);
`else
    #1 chk("odd_stall", 32'(bus.stall),    1);
    tick();
    chk("odd_req",      32'(bus.mem_req),  1);
    chk("odd_addr",     32'(bus.mem_addr), 32'h0041);
    bus.mem_done = 1'b1; bus.mem_rdata = 16'h1111;
    tick(); idle_in();
    chk("odd_wb_err",   32'(bus.wb_err),   0);
    chk("odd_wb_data",  32'(bus.wb_data),  32'h1111);
`endif
    tick();

    // HALT then load
    bus.ex_valid = 1'b1; bus.ex_halt = 1'b1; bus.ex_addr = 16'h00AA;
    tick();
    chk("halt_q",       32'(bus.halt_q),   1);
    chk("halt_wb",      32'(bus.wb_valid), 1);
    chk("halt_wb_data", 32'(bus.wb_data),  32'h00AA);
    bus.ex_halt = 1'b0; bus.ex_rd_en = 1'b1; bus.ex_addr = 16'h0050;
    #1 chk("halt_stall", 32'(bus.stall),   0);
    tick();
    chk("halt_no_req",  32'(bus.mem_req),  0);
    chk("halt_no_wb",   32'(bus.wb_valid), 0);
    tick();
    chk("halt_sticky",  32'(bus.halt_q),   1);
    chk("halt_no_req2", 32'(bus.mem_req),  0);

    // Reset mid-BUSY, late mem_done ignored
    idle_in(); rst = 1'b0;
    tick(); rst = 1'b1;
    chk("rst2_halt",    32'(bus.halt_q),   0);
    bus.ex_valid = 1'b1; bus.ex_wr_en = 1'b1; bus.ex_addr = 16'h0060; bus.ex_wdata = 16'h5555;
    tick();
    chk("rb_req",       32'(bus.mem_req),  1);
    tick();
    rst = 1'b0;
    #1;
    chk("rb_addr",      32'(bus.mem_addr),  0);
    chk("rb_wdata",     32'(bus.mem_wdata), 0);
    chk("rb_wr",        32'(bus.mem_wr),    0);
    chk("rb_stall",     32'(bus.stall),     0);
    idle_in(); rst = 1'b1;
    bus.mem_done = 1'b1; bus.mem_rdata = 16'h7777;
    tick(); bus.mem_done = 1'b0;
    chk("rb_late_wb",   32'(bus.wb_valid), 0);
    chk("rb_late_req",  32'(bus.mem_req),  0);
    bus.ex_valid = 1'b1; bus.ex_addr = 16'h4321;
    tick(); idle_in();
    chk("rb_idle_wb",   32'(bus.wb_valid), 1);
    chk("rb_idle_data", 32'(bus.wb_data),  32'h4321);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
